// File: rtl/latsnq_bank_pkg.sv
// Shared types and helpers for the latsnq_bank storage array.
package latsnq_bank_pkg;

  // Default channel width. The modules re-declare the data type from their own WIDTH.
  localparam int LAT_DEF_WIDTH = 8;

  // Channel data word at the default width.
  typedef logic [LAT_DEF_WIDTH-1:0] lat_data_t;

  // One bit per violation type, used for both the per-cycle events and the sticky flags.
  typedef struct packed {
    logic su;
    logic hd;
    logic rc;
  } viol_t;

  // Number of violation events in one channel's event vector (0..3).
  function automatic logic [1:0] viol_popcount(input viol_t v);
    return {1'b0, v.su} + {1'b0, v.hd} + {1'b0, v.rc};
  endfunction

endpackage

// File: rtl/latsnq_bank_chan.sv
// One storage channel: set-dominant enabled register, input history,
// setup/hold/recovery checks around the falling edge of the enable,
// and the sticky violation flags.
module latsnq_bank_chan
  import latsnq_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic             setn,
  input  logic             clr_viol,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output viol_t            flags,
  output viol_t            ev
);

  typedef logic [WIDTH-1:0] data_t;

  data_t q_q, q_d;
  data_t d_r_q, d_r2_q;
  logic  e_r_q, setn_r_q, setn_r2_q;
  viol_t flag_q, flag_d;
  viol_t ev_c;
  logic  close_c, steady_c;

  // Next stored value: set wins over enable, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (!setn) begin
      q_d = SET_VAL;
    end else if (e) begin
      q_d = d;
    end
  end

  // Violation events are only possible in the cycle where the enable falls.
  // Reset clears the enable history, so the first cycle after reset is always clean.
  always_comb begin
    close_c  = e_r_q & ~e;
    steady_c = setn & setn_r_q;
    ev_c.su  = close_c & steady_c & setn_r2_q & (d_r_q != d_r2_q);
    ev_c.hd  = close_c & steady_c & (d != d_r_q);
    ev_c.rc  = close_c & ((setn & ~setn_r_q) | (setn_r_q & ~setn_r2_q));
    // A clear in the same cycle as an event still leaves that event's flag set.
    flag_d   = clr_viol ? ev_c : viol_t'(flag_q | ev_c);
  end

  // Storage, input history and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= SET_VAL;
      e_r_q     <= 1'b0;
      setn_r_q  <= 1'b1;
      setn_r2_q <= 1'b1;
      d_r_q     <= '0;
      d_r2_q    <= '0;
      flag_q    <= '0;
    end else begin
      q_q       <= q_d;
      e_r_q     <= e;
      setn_r_q  <= setn;
      setn_r2_q <= setn_r_q;
      d_r_q     <= d;
      d_r2_q    <= d_r_q;
      flag_q    <= flag_d;
    end
  end

  assign q     = q_q;
  assign flags = flag_q;
  assign ev    = ev_c;

endmodule

// File: rtl/latsnq_bank.sv
// Bank of independent set-dominant storage channels with timing checks and
// a shared saturating count of violation events.
module latsnq_bank
  import latsnq_bank_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] SET_VAL  = {WIDTH{1'b1}},
  parameter int               CNT_W    = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       E,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       SETN,
  input  logic                      CLR_VIOL,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       VIOL_SU,
  output logic [CHANNELS-1:0]       VIOL_HD,
  output logic [CHANNELS-1:0]       VIOL_RC,
  output logic [CNT_W-1:0]          VIOL_CNT
);

  // Width of the per-cycle event total (0..3*CHANNELS).
  localparam int EV_W  = $clog2(3 * CHANNELS + 1);
  // Sum width large enough that counter + events can never overflow before saturation.
  localparam int SUM_W = ((CNT_W > EV_W) ? CNT_W : EV_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  viol_t            ev_w   [CHANNELS];
  viol_t            flag_w [CHANNELS];
  logic [EV_W-1:0]  ev_sum;
  logic [SUM_W-1:0] base_c, total_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      latsnq_bank_chan #(
        .WIDTH   (WIDTH),
        .SET_VAL (SET_VAL)
      ) u_chan (
        .clk      (CLK),
        .rst      (RST),
        .e        (E[gi]),
        .setn     (SETN[gi]),
        .clr_viol (CLR_VIOL),
        .d        (D[gi*WIDTH +: WIDTH]),
        .q        (Q[gi*WIDTH +: WIDTH]),
        .flags    (flag_w[gi]),
        .ev       (ev_w[gi])
      );
      assign VIOL_SU[gi] = flag_w[gi].su;
      assign VIOL_HD[gi] = flag_w[gi].hd;
      assign VIOL_RC[gi] = flag_w[gi].rc;
    end
  endgenerate

  // Total events this cycle across every channel and violation type.
  always_comb begin
    ev_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ev_sum = ev_sum + EV_W'(viol_popcount(ev_w[c]));
    end
  end

  // Saturating accumulate; a clear restarts from zero but still counts this cycle's events.
  always_comb begin
    base_c  = CLR_VIOL ? '0 : SUM_W'(cnt_q);
    total_c = base_c + SUM_W'(ev_sum);
    if (total_c > CNT_MAX) begin
      cnt_d = '1;
    end else begin
      cnt_d = total_c[CNT_W-1:0];
    end
  end

  // Violation counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign VIOL_CNT = cnt_q;

endmodule

// File: tb/tb_latsnq_bank.sv
module tb_latsnq_bank;

  localparam int WIDTH = 8;
  localparam int CH    = 4;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0]       e_in, setn_in;
  logic [CH*WIDTH-1:0] d_in;
  logic                clr_in;

  logic [CH*WIDTH-1:0] q_w, q_s;
  logic [CH-1:0]       su_w, hd_w, rc_w, su_s, hd_s, rc_s;
  logic [7:0]          cnt_w;
  logic [1:0]          cnt_s;

  always #5 clk = ~clk;

  latsnq_bank #(.WIDTH(WIDTH), .CHANNELS(CH), .SET_VAL(8'hFF), .CNT_W(8)) u_dut (
    .CLK(clk), .RST(rst), .E(e_in), .D(d_in), .SETN(setn_in), .CLR_VIOL(clr_in),
    .Q(q_w), .VIOL_SU(su_w), .VIOL_HD(hd_w), .VIOL_RC(rc_w), .VIOL_CNT(cnt_w)
  );

  // Same stimulus, narrow counter to exercise saturation.
  latsnq_bank #(.WIDTH(WIDTH), .CHANNELS(CH), .SET_VAL(8'hFF), .CNT_W(2)) u_sat (
    .CLK(clk), .RST(rst), .E(e_in), .D(d_in), .SETN(setn_in), .CLR_VIOL(clr_in),
    .Q(q_s), .VIOL_SU(su_s), .VIOL_HD(hd_s), .VIOL_RC(rc_s), .VIOL_CNT(cnt_s)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc_n   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs seen one and two clock edges ago, plus the architectural state.
  logic [CH-1:0]       h_e1, h_setn1, h_setn2;
  logic [CH*WIDTH-1:0] h_d1, h_d2;
  logic [7:0]          m_q [CH];
  logic [CH-1:0]       m_su, m_hd, m_rc;
  int                  m_cnt, m_sat;

  function automatic logic [7:0] dch(input logic [CH*WIDTH-1:0] v, input int c);
    return v[c*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    h_e1 = '0; h_setn1 = '1; h_setn2 = '1; h_d1 = '0; h_d2 = '0;
    for (int c = 0; c < CH; c++) m_q[c] = 8'hFF;
    m_su = '0; m_hd = '0; m_rc = '0;
    m_cnt = 0; m_sat = 0;
  endtask

  task automatic model_step();
    logic [CH-1:0] su_ev, hd_ev, rc_ev;
    int n;
    n = 0;
    for (int c = 0; c < CH; c++) begin
      logic closing, steady;
      closing  = h_e1[c] && !e_in[c];
      steady   = setn_in[c] && h_setn1[c];
      su_ev[c] = closing && steady && h_setn2[c] && (dch(h_d1, c) != dch(h_d2, c));
      hd_ev[c] = closing && steady && (dch(d_in, c) != dch(h_d1, c));
      rc_ev[c] = closing && ((setn_in[c] && !h_setn1[c]) || (h_setn1[c] && !h_setn2[c]));
      n += int'(su_ev[c]) + int'(hd_ev[c]) + int'(rc_ev[c]);
      if (!setn_in[c])  m_q[c] = 8'hFF;
      else if (e_in[c]) m_q[c] = dch(d_in, c);
    end
    if (clr_in) begin
      m_su = su_ev; m_hd = hd_ev; m_rc = rc_ev;
      m_cnt = n; m_sat = n;
    end else begin
      m_su |= su_ev; m_hd |= hd_ev; m_rc |= rc_ev;
      m_cnt += n; m_sat += n;
    end
    if (m_cnt > 255) m_cnt = 255;
    if (m_sat > 3)   m_sat = 3;
    h_setn2 = h_setn1; h_setn1 = setn_in; h_e1 = e_in;
    h_d2 = h_d1; h_d1 = d_in;
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_q;
    for (int c = 0; c < CH; c++) exp_q[c*WIDTH +: WIDTH] = m_q[c];
    check({tag, "_q"},       q_w,   exp_q);
    check({tag, "_su"},      su_w,  32'(m_su));
    check({tag, "_hd"},      hd_w,  32'(m_hd));
    check({tag, "_rc"},      rc_w,  32'(m_rc));
    check({tag, "_cnt"},     cnt_w, 32'(m_cnt));
    check({tag, "_sat_cnt"}, cnt_s, 32'(m_sat));
    check({tag, "_sat_q"},   q_s,   exp_q);
  endtask

  // One clock: sample after the edge, advance the model, compare.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    compare_all("cyc");
    $display("cyc %0d e=%b setn=%b d=%h clr=%b q=%h su=%b hd=%b rc=%b cnt=%0d sat=%0d",
             cyc_n, e_in, setn_in, d_in, clr_in, q_w, su_w, hd_w, rc_w, cnt_w, cnt_s);
    cyc_n++;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    rst = 1'b0;
    $display("reset applied at cycle %0d", cyc_n);
  endtask

  task automatic set_d(input int c, input logic [7:0] v);
    d_in[c*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst = 1'b0;
    // Inputs during reset look like an open enable, then close with new data
    // right after release: no event may appear in that first cycle.
    e_in = '1; setn_in = '1; d_in = 32'hAAAA_AAAA; clr_in = 1'b0;
    do_reset();
    e_in = '0; d_in = 32'h5555_5555;
    cyc();
    check("rst_first_cnt", cnt_w, 32'd0);
    check("rst_first_q",   q_w,   32'hFFFF_FFFF);
    d_in = '0;
    cyc();

    // Capture / hold on channel 0.
    e_in[0] = 1'b1; set_d(0, 8'h3C);
    cyc();
    check("cap_q0", q_w[7:0], 32'h3C);
    cyc(); cyc();
    e_in[0] = 1'b0;
    cyc(); cyc();
    check("cap_hold_q0", q_w[7:0], 32'h3C);
    check("cap_noflags", {su_w, hd_w, rc_w}, 32'd0);

    // Set dominance on channel 1.
    setn_in[1] = 1'b0; e_in[1] = 1'b1; set_d(1, 8'h00);
    cyc();
    check("set_dom_q1", q_w[15:8], 32'hFF);
    setn_in[1] = 1'b1;
    cyc();
    check("set_rel_q1", q_w[15:8], 32'h00);
    cyc(); cyc();
    e_in[1] = 1'b0;
    cyc();
    check("set_no_rc1", rc_w[1], 32'd0);
    check("set_cnt",    cnt_w,   32'd0);

    // Setup violation on channel 2.
    e_in[2] = 1'b1; set_d(2, 8'h11);
    cyc(); cyc();
    set_d(2, 8'h22);
    cyc();
    e_in[2] = 1'b0;
    cyc();
    check("su_flag2", su_w[2], 32'd1);
    check("su_cnt",   cnt_w,   32'd1);

    // Hold violation on channel 2; Q keeps the value from before the closing cycle.
    e_in[2] = 1'b1; set_d(2, 8'h33);
    cyc(); cyc(); cyc();
    e_in[2] = 1'b0; set_d(2, 8'h44);
    cyc();
    check("hd_flag2", hd_w[2], 32'd1);
    check("hd_cnt",   cnt_w,   32'd2);
    check("hd_q2",    q_w[23:16], 32'h33);

    // Recovery on channel 3 simultaneous with hold on channel 0.
    for (int pass = 0; pass < 2; pass++) begin
      setn_in[3] = 1'b0; e_in[3] = 1'b1; e_in[0] = 1'b1; set_d(0, 8'h50);
      cyc(); cyc();
      e_in[3] = 1'b0; setn_in[3] = 1'b1; e_in[0] = 1'b0; set_d(0, 8'h51);
      clr_in = (pass == 1);
      cyc();
      clr_in = 1'b0;
      check("rc_flag3", rc_w[3], 32'd1);
      check("rc_hd0",   hd_w[0], 32'd1);
      if (pass == 0) begin
        check("rc_cnt", cnt_w, 32'd4);
      end else begin
        check("rc_clr_cnt", cnt_w, 32'd2);
        check("rc_clr_su",  su_w,  32'd0);
        check("rc_clr_hd",  hd_w,  32'b0001);
        check("rc_clr_rc",  rc_w,  32'b1000);
      end
      cyc();
    end

    // Saturation of the 2-bit counter.
    clr_in = 1'b1;
    cyc();
    clr_in = 1'b0;
    check("sat_clr0", cnt_s, 32'd0);
    e_in = '1; d_in = 32'h0102_0304;
    cyc(); cyc();
    e_in = '0; d_in = 32'h0A0B_0C0D;
    cyc();
    check("sat_4ev",      cnt_s, 32'd3);
    check("sat_4ev_wide", cnt_w, 32'd4);
    e_in[0] = 1'b1;
    cyc(); cyc();
    e_in[0] = 1'b0; set_d(0, 8'hEE);
    cyc();
    check("sat_5ev",      cnt_s, 32'd3);
    check("sat_5ev_wide", cnt_w, 32'd5);
    clr_in = 1'b1;
    cyc();
    clr_in = 1'b0;
    check("sat_clr", cnt_s, 32'd0);

    // Randomised traffic with periodic mid-run resets.
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 100; i++) begin
        for (int c = 0; c < CH; c++) begin
          e_in[c]    = ($urandom_range(0, 2) != 0);
          setn_in[c] = ($urandom_range(0, 5) != 0);
          if ($urandom_range(0, 1) == 1) set_d(c, 8'($urandom_range(0, 3) * 17));
        end
        clr_in = ($urandom_range(0, 19) == 0);
        cyc();
      end
      clr_in = 1'b0;
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
